// File: rtl/inst_encoder_if.sv
// Request/write-port bundle for the instruction encoder.
// The encoder sits on the slave side; the program builder drives the master side.
interface inst_encoder_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
);
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic              i_valid;
  logic              o_ready;
  logic              i_last;
  logic [6:0]        i_opcode;
  logic [2:0]        i_funct3;
  logic [6:0]        i_funct7;
  logic [4:0]        i_rd;
  logic [4:0]        i_rs1;
  logic [4:0]        i_rs2;
  logic [ADDR_W-1:0] i_imm;
  logic              o_mem_wen;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic              i_mem_stall;
  logic [CNT_W-1:0]  o_count;
  logic              o_done;
  logic              o_err;
  logic [1:0]        o_err_code;

  modport master (
    output i_start, i_base_addr, i_valid, i_last, i_opcode, i_funct3, i_funct7,
           i_rd, i_rs1, i_rs2, i_imm, i_mem_stall,
    input  o_ready, o_mem_wen, o_mem_addr, o_mem_wdata, o_count, o_done,
           o_err, o_err_code
  );

  modport slave (
    input  i_start, i_base_addr, i_valid, i_last, i_opcode, i_funct3, i_funct7,
           i_rd, i_rs1, i_rs2, i_imm, i_mem_stall,
    output o_ready, o_mem_wen, o_mem_addr, o_mem_wdata, o_count, o_done,
           o_err, o_err_code
  );
endinterface

// File: rtl/inst_encoder.sv
// Packs decoded fields plus a zero-extended immediate into a 32-bit RV64 word
// and streams the words into instruction memory from a programmable base.
module inst_encoder #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  inst_encoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RUN, WRITE, DONE, ERR} state_e;
  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_S, FMT_B} fmt_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_CLASS = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_ALIGN = 2'b11;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [ADDR_W-1:0] imm;
  } req_t;

  req_t              req;
  fmt_e              fmt;
  logic              illegal;
  logic [31:0]       word_d;
  logic [1:0]        code_d;

  state_e            state_q;
  logic              ready_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  count_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        code_q;
  logic              last_q;

  always_comb begin
    req.opcode = bus.i_opcode;
    req.funct3 = bus.i_funct3;
    req.funct7 = bus.i_funct7;
    req.rd     = bus.i_rd;
    req.rs1    = bus.i_rs1;
    req.rs2    = bus.i_rs2;
    req.imm    = bus.i_imm;
  end

  // The R opcode shares opcode[6:5]=01 with stores, so it is matched first.
  always_comb begin
    fmt     = FMT_I;
    illegal = 1'b0;
    if (req.opcode == 7'b0110011) begin
      fmt = FMT_R;
    end else begin
      unique case (req.opcode[6:5])
        2'b00:   fmt = FMT_I;
        2'b01:   fmt = FMT_S;
        2'b11:   fmt = FMT_B;
        default: illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    word_d = '0;
    unique case (fmt)
      FMT_R: word_d = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
      FMT_I: word_d = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
      FMT_S: word_d = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0],
                       req.opcode};
      FMT_B: word_d = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                       req.imm[4:1], req.imm[11], req.opcode};
      default: word_d = '0;
    endcase
  end

  // Misalignment outranks range so an odd, oversized branch reports 11.
  always_comb begin
    code_d = ERR_NONE;
    if (illegal)
      code_d = ERR_CLASS;
    else if (fmt == FMT_B && req.imm[0])
      code_d = ERR_ALIGN;
    else if (((fmt == FMT_I || fmt == FMT_S) && |req.imm[ADDR_W-1:12]) ||
             (fmt == FMT_B && |req.imm[ADDR_W-1:13]))
      code_d = ERR_RANGE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      last_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, ERR: begin
          if (bus.i_start) begin
            state_q <= RUN;
            ready_q <= 1'b1;
            addr_q  <= bus.i_base_addr;
            count_q <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
          end
        end
        RUN: begin
          if (bus.i_valid) begin
            wdata_q <= word_d;
            last_q  <= bus.i_last;
            ready_q <= 1'b0;
            if (code_d != ERR_NONE) begin
              state_q <= ERR;
              err_q   <= 1'b1;
              code_q  <= code_d;
            end else begin
              state_q <= WRITE;
              wen_q   <= 1'b1;
            end
          end
        end
        WRITE: begin
          // Address, data and enable stay frozen until memory takes the word.
          if (!bus.i_mem_stall) begin
            wen_q   <= 1'b0;
            addr_q  <= addr_q + ADDR_W'(4);
            count_q <= count_q + CNT_W'(1);
            if (last_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              ready_q <= 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_mem_wen   = wen_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_count     = count_q;
  assign bus.o_done      = done_q;
  assign bus.o_err       = err_q;
  assign bus.o_err_code  = code_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: driver pushes expected writes/errors/done,
// a negedge monitor pops and compares, and decodes words back to immediates.
module tb_inst_encoder;
  localparam int AW = 64;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_encoder_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();
  inst_encoder #(.ADDR_W(AW), .CNT_W(CW)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;
  int stall_mode = 0;

  typedef struct {
    int          kind;   // 0 write, 1 error, 2 done
    logic [63:0] addr;
    logic [31:0] data;
    logic [1:0]  code;
    logic [31:0] cnt;
    int          cls;
    logic [63:0] imm;
  } item_t;
  item_t sbq[$];

  logic [63:0] e_addr;
  logic [31:0] e_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // 0 R, 1 I, 2 S, 3 B, 4 illegal
  function automatic int cls_of(input logic [6:0] op);
    if (op == 7'h33) return 0;
    case (int'(op) / 32)
      0: return 1;
      1: return 2;
      3: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [1:0] model_code(input logic [6:0] op, input logic [63:0] imm);
    int c = cls_of(op);
    if (c == 4) return 2'b01;
    if (c == 3 && imm % 2 == 1) return 2'b11;
    if ((c == 1 || c == 2) && imm >= 64'd4096) return 2'b10;
    if (c == 3 && imm >= 64'd8192) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_word(input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [63:0] imm);
    logic [63:0] a;
    a = 64'(op) + 64'(f3) * 4096 + 64'(rs1) * 32768;
    case (cls_of(op))
      0: a = a + 64'(rd) * 128 + 64'(rs2) * 1048576 + 64'(f7) * 33554432;
      1: a = a + 64'(rd) * 128 + (imm % 4096) * 1048576;
      2: a = a + (imm % 32) * 128 + 64'(rs2) * 1048576 + ((imm / 32) % 128) * 33554432;
      default: a = a + ((imm / 2) % 16) * 256 + ((imm / 2048) % 2) * 128
                 + 64'(rs2) * 1048576 + ((imm / 32) % 64) * 33554432
                 + ((imm / 4096) % 2) * 64'h8000_0000;
    endcase
    return a[31:0];
  endfunction

  // Immediate generator, zero-extended output.
  function automatic logic [63:0] immgen(input logic [31:0] w, input int c);
    case (c)
      1: return 64'(w[31:20]);
      2: return 64'({w[31:25], w[11:7]});
      default: return 64'({w[31], w[7], w[30:25], w[11:8], 1'b0});
    endcase
  endfunction

  task automatic pop(input int kind, output item_t it, output bit ok);
    total++;
    ok = 1'b0;
    it = '{default: '0};
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL sb_unexpected kind=%0d with empty queue", kind);
    end else begin
      it = sbq.pop_front();
      if (it.kind != kind) begin
        bad++;
        $display("FAIL sb_kind actual=%0d expected=%0d", kind, it.kind);
      end else ok = 1'b1;
    end
  endtask

  // Monitor
  initial begin
    bit err_prev = 1'b0;
    item_t it;
    bit ok;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.o_mem_wen && !bus.i_mem_stall) begin
          pop(0, it, ok);
          if (ok) begin
            chk("wr_addr", bus.o_mem_addr, it.addr);
            chk("wr_data", 64'(bus.o_mem_wdata), 64'(it.data));
            if (it.cls >= 1 && it.cls <= 3)
              chk("roundtrip_imm", immgen(bus.o_mem_wdata, it.cls), it.imm);
          end
        end
        if (bus.o_err && !err_prev) begin
          pop(1, it, ok);
          if (ok) chk("err_code", 64'(bus.o_err_code), 64'(it.code));
        end
        if (bus.o_done) begin
          pop(2, it, ok);
          if (ok) chk("done_count", 64'(bus.o_count), 64'(it.cnt));
        end
        err_prev = bus.o_err;
      end else err_prev = 1'b0;
    end
  end

  // Memory stall driver: 0 off, 1 random, 2 forced
  initial begin
    bus.i_mem_stall = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (stall_mode)
        1: bus.i_mem_stall = ($urandom_range(0, 3) == 0);
        2: bus.i_mem_stall = 1'b1;
        default: bus.i_mem_stall = 1'b0;
      endcase
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [63:0] base);
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    bus.i_base_addr = base;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    e_addr = base;
    e_cnt = '0;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [63:0] imm, input bit last, input logic [31:0] want, input bit use_want,
      output bit errd);
    item_t it;
    bit got = 1'b0;
    logic [1:0] c;
    errd = 1'b0;
    bus.i_opcode = op; bus.i_funct3 = f3; bus.i_funct7 = f7;
    bus.i_rd = rd; bus.i_rs1 = rs1; bus.i_rs2 = rs2; bus.i_imm = imm;
    bus.i_last = last; bus.i_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.o_ready) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL ready_timeout op=%0h", op);
      bus.i_valid = 1'b0;
      errd = 1'b1;
      return;
    end
    c = model_code(op, imm);
    it = '{default: '0};
    if (c != 2'b00) begin
      it.kind = 1; it.code = c;
      sbq.push_back(it);
      errd = 1'b1;
    end else begin
      it.kind = 0; it.addr = e_addr;
      it.data = use_want ? want : model_word(op, f3, f7, rd, rs1, rs2, imm);
      it.cls = cls_of(op); it.imm = imm;
      sbq.push_back(it);
      e_addr = e_addr + 64'd4;
      e_cnt = e_cnt + 32'd1;
      if (last) begin
        it = '{default: '0};
        it.kind = 2; it.cnt = e_cnt;
        sbq.push_back(it);
      end
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    bit empty = 1'b0;
    for (int i = 0; i < 400 && !empty; i++) begin
      @(posedge clk);
      if (sbq.size() == 0) empty = 1'b1;
    end
    if (!empty) begin
      total++; bad++;
      $display("FAIL drain_timeout pending=%0d", sbq.size());
      sbq.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bit e;
    bus.i_start = 1'b0; bus.i_base_addr = '0; bus.i_valid = 1'b0; bus.i_last = 1'b0;
    bus.i_opcode = '0; bus.i_funct3 = '0; bus.i_funct7 = '0;
    bus.i_rd = '0; bus.i_rs1 = '0; bus.i_rs2 = '0; bus.i_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.o_ready), 64'd0);
    chk("rst_wen", 64'(bus.o_mem_wen), 64'd0);
    chk("rst_addr", bus.o_mem_addr, 64'd0);
    chk("rst_wdata", 64'(bus.o_mem_wdata), 64'd0);
    chk("rst_count", 64'(bus.o_count), 64'd0);
    chk("rst_done", 64'(bus.o_done), 64'd0);
    chk("rst_err", 64'(bus.o_err), 64'd0);
    chk("rst_code", 64'(bus.o_err_code), 64'd0);
    rst_n = 1'b1;

    // single addi
    do_start(64'h100);
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd5, 1'b1, 32'h00500093, 1'b1, e);
    drain();
    chk("single_count", 64'(bus.o_count), 64'd1);

    // four-word program
    do_start(64'h0);
    send(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0, 1'b0, 32'h002081B3, 1'b1, e);
    send(7'h23, 3'd3, 7'd0, 5'd0, 5'd1, 5'd2, 64'd8, 1'b0, 32'h0020B423, 1'b1, e);
    send(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'd16, 1'b0, 32'h00208863, 1'b1, e);
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd5, 1'b1, 32'h00500093, 1'b1, e);
    drain();
    chk("stream_count", 64'(bus.o_count), 64'd4);

    // held write under stall
    stall_mode = 2;
    do_start(64'h200);
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd5, 1'b1, 32'h00500093, 1'b1, e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_wen", 64'(bus.o_mem_wen), 64'd1);
      chk("stall_addr", bus.o_mem_addr, 64'h200);
      chk("stall_wdata", 64'(bus.o_mem_wdata), 64'h00500093);
      chk("stall_ready", 64'(bus.o_ready), 64'd0);
      chk("stall_count", 64'(bus.o_count), 64'd0);
    end
    stall_mode = 0;
    drain();
    chk("stall_count_after", 64'(bus.o_count), 64'd1);

    // error classes
    do_start(64'h0);
    send(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'h11, 1'b1, 32'h0, 1'b0, e);
    drain();
    chk("err_nowrite_wen", 64'(bus.o_mem_wen), 64'd0);
    chk("err_count", 64'(bus.o_count), 64'd0);
    chk("err_ready", 64'(bus.o_ready), 64'd0);
    do_start(64'h0);
    chk("clr_err", 64'(bus.o_err), 64'd0);
    chk("clr_code", 64'(bus.o_err_code), 64'd0);
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'h1000, 1'b1, 32'h0, 1'b0, e);
    drain();
    do_start(64'h0);
    send(7'h53, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 64'd0, 1'b1, 32'h0, 1'b0, e);
    drain();
    do_start(64'h0);
    chk("clr_err2", 64'(bus.o_err), 64'd0);
    chk("clr_code2", 64'(bus.o_err_code), 64'd0);
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd7, 1'b1, 32'h0, 1'b0, e);
    drain();

    // random legal I/S/B with random stalls, incl. address wrap
    stall_mode = 1;
    for (int p = 0; p < 25; p++) begin
      int n = $urandom_range(1, 4);
      logic [63:0] base = (p == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom & 32'hFFFF_FFFC};
      do_start(base);
      for (int k = 0; k < n; k++) begin
        int c = $urandom_range(1, 3);
        logic [4:0] low = 5'($urandom_range(0, 31));
        logic [6:0] op;
        logic [63:0] imm;
        if (c == 1) op = {2'b00, low};
        else if (c == 2) op = {2'b01, (low == 5'b10011) ? 5'b00011 : low};
        else op = {2'b11, low};
        imm = (c == 3) ? 64'($urandom_range(0, 4095)) * 2 : 64'($urandom_range(0, 4095));
        send(op, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             imm, k == n - 1, 32'h0, 1'b0, e);
      end
      drain();
    end

    // random mix including illegal requests
    for (int p = 0; p < 20; p++) begin
      int n = $urandom_range(1, 4);
      do_start({$urandom, $urandom & 32'hFFFF_FFFC});
      for (int k = 0; k < n; k++) begin
        logic [63:0] imm;
        case ($urandom_range(0, 3))
          0: imm = 64'($urandom_range(0, 8191));
          1: imm = 64'($urandom_range(0, 4095));
          2: imm = {$urandom, $urandom};
          default: imm = 64'h1000 << $urandom_range(0, 40);
        endcase
        send(7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             imm, k == n - 1, 32'h0, 1'b0, e);
        if (e) break;
      end
      drain();
    end

    // async reset while a write is stalled
    stall_mode = 2;
    do_start(64'h300);
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd5, 1'b1, 32'h00500093, 1'b1, e);
    @(negedge clk);
    chk("pre_rst_wen", 64'(bus.o_mem_wen), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wen", 64'(bus.o_mem_wen), 64'd0);
    chk("arst_count", 64'(bus.o_count), 64'd0);
    chk("arst_addr", bus.o_mem_addr, 64'd0);
    chk("arst_ready", 64'(bus.o_ready), 64'd0);
    sbq.delete();
    stall_mode = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_ready", 64'(bus.o_ready), 64'd0);
    end
    do_start(64'h400);
    send(7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 64'd9, 1'b1, 32'h0, 1'b0, e);
    drain();
    chk("restart_count", 64'(bus.o_count), 64'd1);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
